mem_bhw_unit: RTL

Data-memory access unit directly downstream of the memory functional unit. Accepts one address/data/write-enable/width request (RISC-V funct3 width encoding), performs byte/half/word loads with sign or zero extension, and byte/half stores as read-modify-write on a word-wide synchronous RAM. Returns a registered load result or store completion with a one-cycle `done` pulse and an alignment error flag. Fixed latency, one request in flight.

---
 rtl/mem_bhw_unit_pkg.sv | 76 +++++++
 rtl/mem_bhw_unit_if.sv | 23 ++
 rtl/mem_bhw_unit_ram.sv | 23 ++
 rtl/mem_bhw_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mem_bhw_unit_pkg.sv
// Shared definitions for the byte/half/word memory access unit:
// funct3 width codes, the control FSM state type, and the lane
// select / extension / merge helpers used by the datapath.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_MRG  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // A request is rejected when its address is misaligned for its width,
  // when funct3 is not a defined width, or when a store uses an unsigned code.
  function automatic logic req_error(input logic [1:0] off,
                                     input logic [2:0] f3,
                                     input logic       we);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = (off != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Picks the addressed byte/half out of a little-endian word and extends it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    res = {{24{b[7]}}, b};
      F3_BU:   res = {24'h000000, b};
      F3_H:    res = {{16{h[15]}}, h};
      F3_HU:   res = {16'h0000, h};
      F3_W:    res = word;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

  // Overlays the low byte/half of the store data onto the old word at the
  // addressed lane; a full-word store simply replaces the word.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0] res;
    res = word;
    case (f3)
      F3_B: res[{off, 3'b000} +: 8] = data[7:0];
      F3_H: begin
        if (off[1]) res[31:16] = data[15:0];
        else        res[15:0]  = data[15:0];
      end
      F3_W:    res = data;
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_bhw_unit_if.sv
// Request/response bundle between the memory functional unit (master)
// and the byte/half/word access unit (slave).
interface mem_bhw_unit_if;
  logic        req;
  logic [31:0] addra;
  logic [31:0] dina;
  logic        wea;
  logic [2:0]  mem_u_b_h_w;
  logic        busy;
  logic        done;
  logic [31:0] douta;
  logic        err;

  modport master (
    output req, addra, dina, wea, mem_u_b_h_w,
    input  busy, done, douta, err
  );

  modport slave (
    input  req, addra, dina, wea, mem_u_b_h_w,
    output busy, done, douta, err
  );
endinterface

// File: rtl/mem_bhw_unit_ram.sv
// Word-wide single-port RAM with one-cycle synchronous read. A read in the
// same cycle as a write to the same word returns the old contents.
module ram_word_sync #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [0:DEPTH-1];

  // Registered read of the old word alongside an optional write.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bhw_unit.sv
// Data-memory access unit: captures one request, reads the addressed word,
// then either extends the selected lane for a load or merges the store
// data back into the word. Completion is a one-cycle done pulse.
module mem_bhw_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic          clk,
  input  logic          rst,
  mem_bhw_unit_if.slave bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH+1:0] addr_q,  addr_d;
  logic [31:0]           data_q,  data_d;
  logic                  we_q,    we_d;
  logic [2:0]            f3_q,    f3_d;
  logic                  bad_q,   bad_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;
  logic [31:0]           douta_q, douta_d;
  logic                  err_q,   err_d;

  logic [31:0]           ram_rdata;
  logic [31:0]           ram_wdata;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;

  // Address bits above the RAM size are dropped so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addra[31:ADDR_WIDTH+2];

  // RAM port: always addressed by the captured word index; the write is only
  // enabled in MRG for a legal store and is suppressed by a reset that edge.
  assign ram_addr  = addr_q[ADDR_WIDTH+1:2];
  assign ram_wdata = store_merge(ram_rdata, data_q, addr_q[1:0], f3_q);
  assign ram_we    = (state_q == ST_MRG) && we_q && !bad_q && !rst;

  ram_word_sync #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Next-state and next-output computation for the capture/read/merge/done sequence.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    f3_d    = f3_q;
    bad_d   = bad_q;
    douta_d = douta_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          addr_d  = bus.addra[ADDR_WIDTH+1:0];
          data_d  = bus.dina;
          we_d    = bus.wea;
          f3_d    = bus.mem_u_b_h_w;
          bad_d   = req_error(bus.addra[1:0], bus.mem_u_b_h_w, bus.wea);
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        state_d = ST_MRG;
      end
      ST_MRG: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        if (bad_q) begin
          douta_d = 32'h0;
          err_d   = 1'b1;
        end else if (we_q) begin
          douta_d = 32'h0;
          err_d   = 1'b0;
        end else begin
          douta_d = load_extend(ram_rdata, addr_q[1:0], f3_q);
          err_d   = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset abandons any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= 32'h0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      douta_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      douta_q <= douta_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.douta = douta_q;
  assign bus.err   = err_q;

endmodule
